// File: rtl/ext_bus_if.sv
// CPU external bus as seen by memory-mapped peripherals.
// The CPU side drives address, strobes and write data.
interface ext_bus_if;
   logic [17:0] dir_mem_ex;
   logic        write_ext;
   logic        read_ext;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_oe;

   modport master (
      output dir_mem_ex,
      output write_ext,
      output read_ext,
      output data_in,
      input  data_out,
      input  data_oe
   );

   modport slave (
      input  dir_mem_ex,
      input  write_ext,
      input  read_ext,
      input  data_in,
      output data_out,
      output data_oe
   );
endinterface

// File: rtl/ext_io_timer.sv
// External-bus peripheral: 4-digit hex display register and a
// prescaled 16-bit timer with compare match and sticky status.
module ext_io_timer #(
   parameter logic [1:0]  BASE_HI = 2'b11,
   parameter logic [15:0] CMP_RST = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   ext_bus_if.slave   bus,
   output logic [6:0] out_d0,
   output logic [6:0] out_d1,
   output logic [6:0] out_d2,
   output logic [6:0] out_d3
);

   logic        sel;
   logic        wr;
   logic [2:0]  off;
   logic [7:0]  we;
   logic        unused_addr;

   logic [15:0] disp;
   logic [2:0]  ctrl;
   logic [15:0] presc;
   logic [15:0] pcnt;
   logic [15:0] count;
   logic [15:0] cmp;
   logic        match;

   logic        en;
   logic        ar;
   logic        blank;
   logic        tick;
   logic        hit;
   logic [15:0] rdata;

   assign sel = (bus.dir_mem_ex[17:16] == BASE_HI);
   assign off = bus.dir_mem_ex[2:0];
   assign wr  = sel & bus.write_ext;
   assign we  = wr ? (8'b1 << off) : 8'b0;

   // Upper window bits alias the register file.
   assign unused_addr = ^bus.dir_mem_ex[15:3];

   assign en    = ctrl[0];
   assign ar    = ctrl[1];
   assign blank = ctrl[2];
   assign tick  = en & (pcnt == 16'h0);
   assign hit   = (count == cmp);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp  <= 16'h0;
         ctrl  <= 3'b0;
         presc <= 16'h0;
         cmp   <= CMP_RST;
      end else begin
         if (we[0]) disp  <= bus.data_in;
         if (we[1]) ctrl  <= bus.data_in[2:0];
         if (we[2]) presc <= bus.data_in;
         if (we[4]) cmp   <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt <= 16'h0;
      end else if (we[2]) begin
         pcnt <= bus.data_in;
      end else if (en) begin
         pcnt <= (pcnt == 16'h0) ? presc : pcnt - 16'h1;
      end
   end

   // A CPU write to COUNT overrides the tick increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 16'h0;
      end else if (we[3]) begin
         count <= bus.data_in;
      end else if (tick) begin
         count <= (hit & ar) ? 16'h0 : count + 16'h1;
      end
   end

   // Setting MATCH takes priority over a STATUS clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match <= 1'b0;
      end else if (tick & hit) begin
         match <= 1'b1;
      end else if (we[5] & bus.data_in[0]) begin
         match <= 1'b0;
      end
   end

   always_comb begin
      rdata = 16'h0;
      case (off)
         3'd0:    rdata = disp;
         3'd1:    rdata = {13'h0, ctrl};
         3'd2:    rdata = presc;
         3'd3:    rdata = count;
         3'd4:    rdata = cmp;
         3'd5:    rdata = {15'h0, match};
         default: rdata = 16'h0;
      endcase
   end

   assign bus.data_oe  = sel & bus.read_ext;
   assign bus.data_out = bus.data_oe ? rdata : 16'h0;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign out_d0 = blank ? 7'h7F : seg7(disp[3:0]);
   assign out_d1 = blank ? 7'h7F : seg7(disp[7:4]);
   assign out_d2 = blank ? 7'h7F : seg7(disp[11:8]);
   assign out_d3 = blank ? 7'h7F : seg7(disp[15:12]);

endmodule
